// File: rtl/generation_counter_display.sv
// Decimal generation counter for the Game of Life board with its own tick divider.
// Drives NUM_DIGITS active-low seven-segment displays, digit 0 (ones) in hex[6:0].
module generation_counter_display #(
    parameter int NUM_DIGITS    = 4,
    parameter int TICK_DIV      = 33_000_000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    clear,
    output logic [7*NUM_DIGITS-1:0] hex,
    output logic                    genTick,
    output logic                    overflow
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    localparam logic [1:0] OFF   = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [1:0]                 state;
    logic [DW-1:0]              div;
    logic [NUM_DIGITS-1:0][3:0] digits;
    logic [NUM_DIGITS-1:0][3:0] digits_inc;
    logic                       tick;
    logic                       all_nine;
    logic                       carry;
    logic                       zero_run;
    logic                       blank;

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign tick = (state == RUN) && (div == DIV_LAST);

    // BCD ripple increment of the whole count, plus all-nines detection for wrap
    always_comb begin
        carry      = 1'b1;
        all_nine   = 1'b1;
        digits_inc = digits;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            all_nine = all_nine && (digits[i] == 4'd9);
            if (carry) begin
                if (digits[i] == 4'd9) begin
                    digits_inc[i] = 4'd0;
                end else begin
                    digits_inc[i] = digits[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    // Run-control state: OFF only leaves on start, RUN/PAUSE follow the pause level
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OFF;
        end else begin
            case (state)
                OFF:     if (start)  state <= RUN;
                RUN:     if (pause)  state <= PAUSE;
                PAUSE:   if (!pause) state <= RUN;
                default: state <= OFF;
            endcase
        end
    end

    // Tick divider: advances only in RUN, frozen in PAUSE, parked at zero in OFF
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
        end else if (state == OFF) begin
            div <= '0;
        end else if (state == RUN) begin
            div <= tick ? '0 : div + 1'b1;
        end
    end

    // Count and sticky overflow; clear beats a same-cycle tick
    always_ff @(posedge clk) begin
        if (reset) begin
            digits   <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            digits   <= '0;
            overflow <= 1'b0;
        end else if (tick) begin
            digits <= digits_inc;
            if (all_nine) overflow <= 1'b1;
        end
    end

    // Generation pulse lines up with the freshly incremented count
    always_ff @(posedge clk) begin
        if (reset) genTick <= 1'b0;
        else       genTick <= tick;
    end

    // Segment drive, blanking leading zeros from the top digit downward
    always_comb begin
        zero_run = 1'b1;
        blank    = 1'b1;
        hex      = '1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (digits[i] == 4'd0);
            blank    = (state == OFF) ||
                       ((BLANK_LEADING != 0) && (i != 0) && zero_run);
            hex[7*i +: 7] = blank ? 7'b1111111 : seg(digits[i]);
        end
    end

endmodule

// File: tb/tb_generation_counter_display.sv
// Randomised scoreboard bench for generation_counter_display (2 digits, divide-by-4),
// running a leading-blank build and a show-all build side by side.
module tb_generation_counter_display;

    localparam int ND  = 2;
    localparam int TD  = 4;
    localparam int MAXC = 99;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic pause = 1'b0;
    logic clear = 1'b0;

    logic [7*ND-1:0] hex_a;
    logic [7*ND-1:0] hex_b;
    logic            gt_a, gt_b;
    logic            ov_a, ov_b;

    generation_counter_display #(
        .NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .clear(clear), .hex(hex_a), .genTick(gt_a), .overflow(ov_a)
    );

    generation_counter_display #(
        .NUM_DIGITS(ND), .TICK_DIV(TD), .BLANK_LEADING(0)
    ) dut_nb (
        .clk(clk), .reset(reset), .start(start), .pause(pause),
        .clear(clear), .hex(hex_b), .genTick(gt_b), .overflow(ov_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7*ND-1:0] ha;
        logic [7*ND-1:0] hb;
        logic            gt;
        logic            ov;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // reference model: 0=off 1=running 2=paused, count as a plain integer
    int m_st = 0;
    int m_cnt = 0;
    int m_div = 0;
    bit m_ovf = 0;
    bit m_gt = 0;

    logic [6:0] segtab [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [7*ND-1:0] disp(int cnt, int st, bit bl);
        logic [7*ND-1:0] h;
        int p;
        h = '1;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            if (st != 0 && !(bl && i > 0 && cnt < p))
                h[7*i +: 7] = segtab[(cnt / p) % 10];
            p = p * 10;
        end
        return h;
    endfunction

    task automatic model_step(bit r, bit s, bit p, bit c);
        bit tk;
        if (r) begin
            m_st = 0; m_cnt = 0; m_div = 0; m_ovf = 0; m_gt = 0;
        end else begin
            tk = (m_st == 1) && (m_div == TD - 1);
            m_gt = tk;
            if (m_st == 0)      m_div = 0;
            else if (m_st == 1) m_div = tk ? 0 : m_div + 1;
            if (c) begin
                m_cnt = 0; m_ovf = 0;
            end else if (tk) begin
                if (m_cnt == MAXC) begin
                    m_cnt = 0; m_ovf = 1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (m_st == 0 && s)       m_st = 1;
            else if (m_st == 1 && p)  m_st = 2;
            else if (m_st == 2 && !p) m_st = 1;
        end
    endtask

    task automatic drive(bit r, bit s, bit p, bit c);
        exp_t e;
        reset = r; start = s; pause = p; clear = c;
        model_step(r, s, p, c);
        e.ha = disp(m_cnt, m_st, 1'b1);
        e.hb = disp(m_cnt, m_st, 1'b0);
        e.gt = m_gt;
        e.ov = m_ovf;
        q.push_back(e);
        @(negedge clk);
    endtask

    // monitor: one expected entry per clock, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                cyc++;
                checks += 6;
                if (hex_a !== e.ha) begin
                    errors++;
                    $display("FAIL hex_blank cyc %0d got %h exp %h", cyc, hex_a, e.ha);
                end
                if (hex_b !== e.hb) begin
                    errors++;
                    $display("FAIL hex_full cyc %0d got %h exp %h", cyc, hex_b, e.hb);
                end
                if (gt_a !== e.gt) begin
                    errors++;
                    $display("FAIL genTick cyc %0d got %b exp %b", cyc, gt_a, e.gt);
                end
                if (gt_b !== e.gt) begin
                    errors++;
                    $display("FAIL genTick_nb cyc %0d got %b exp %b", cyc, gt_b, e.gt);
                end
                if (ov_a !== e.ov) begin
                    errors++;
                    $display("FAIL overflow cyc %0d got %b exp %b", cyc, ov_a, e.ov);
                end
                if (ov_b !== e.ov) begin
                    errors++;
                    $display("FAIL overflow_nb cyc %0d got %b exp %b", cyc, ov_b, e.ov);
                end
            end
        end
    end

    initial begin
        bit hit;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (10) drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        // through 9->10 and 99->0 wrap, then extra ticks with overflow held
        repeat (440) drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        repeat (6) drive(0, 0, 0, 0);
        // pause while the divider sits at 2
        for (int i = 0; i < 8 && !(m_st == 1 && m_div == 2); i++)
            drive(0, 0, 0, 0);
        repeat (7) drive(0, 0, 1, 0);
        repeat (6) drive(0, 0, 0, 0);
        // clear landing on a tick cycle
        hit = 0;
        for (int i = 0; i < 8 && !hit; i++) begin
            if (m_st == 1 && m_div == TD - 1) begin
                drive(0, 0, 0, 1);
                hit = 1;
            end else begin
                drive(0, 0, 0, 0);
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL clear_on_tick got no_tick exp tick");
        end
        repeat (3) drive(0, 0, 0, 0);
        // reset mid-run with every other input high
        drive(1, 1, 1, 1);
        drive(0, 0, 0, 0);
        drive(0, 1, 0, 0);
        repeat (10) drive(0, 0, 0, 0);
        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(199) == 0),
                  ($urandom_range(7) == 0),
                  ($urandom_range(4) == 0),
                  ($urandom_range(49) == 0));
        end
        reset = 0; start = 0; pause = 0; clear = 0;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d exp 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
